game_tick_scheduler: RTL
========================

GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 28, width of the period counter.
REQ-002 SHALL have parameter BASE_COUNT, default 28'd49_999_999, reload value at level 0 (1 Hz step at 50 MHz).
REQ-003 SHALL have parameter RAMP_STEPS, default 16, number of completed steps per automatic level increase.
REQ-004 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port clear_b  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port start  input  1  level-sensitive start/acknowledge request.
REQ-007 SHALL have port pause  input  1  level-sensitive pause request.
REQ-008 SHALL have port crash  input  1  collision report from the game datapath.
REQ-009 SHALL have port start_level  input  2  initial speed level, sampled on IDLE->RUN.
REQ-010 SHALL have port move_p1  output  1  one-cycle pulse: advance player 1.
REQ-011 SHALL have port move_p2  output  1  one-cycle pulse: advance player 2.
REQ-012 SHALL have port step_done  output  1  one-cycle pulse: collision check / redraw slot.
REQ-013 SHALL have port level  output  2  current speed level, 0 slowest, 3 fastest.
REQ-014 SHALL have ports running, paused, game_over  output  1 each  state flags, registered.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, OVER; running/paused/game_over high only in RUN/PAUSE/OVER respectively.
REQ-016 Reload value SHALL be max(BASE_COUNT >> level, 3), computed at DIV_WIDTH bits.
REQ-017 IDLE with start=1 SHALL go to RUN next cycle, loading level<=start_level, counter<=reload(start_level), step count<=0.
REQ-018 In RUN with counter!=0, counter SHALL decrement by 1 per cycle.
REQ-019 In RUN with counter==0, counter SHALL reload with the current reload value and a 3-cycle phase sequence SHALL start; step period = reload+1 cycles.
REQ-020 Phase sequence: move_p1 high the cycle after counter==0, move_p2 the next cycle, step_done the cycle after; never two pulses in one cycle.
REQ-021 On each step_done, step count SHALL increment; at RAMP_STEPS-1 it SHALL wrap to 0 and level SHALL increment, saturating at 3.
REQ-022 A new level SHALL take effect at the next reload; the counter SHALL NOT be reloaded on a level change.
REQ-023 pause=1 in RUN SHALL enter PAUSE only when no phase sequence is in progress; otherwise the sequence completes first, then PAUSE.
REQ-024 In PAUSE, counter, level, step count SHALL hold and no pulses SHALL issue; pause=0 SHALL return to RUN, resuming the count from the held value.
REQ-025 crash=1 in RUN or PAUSE SHALL enter OVER next cycle, with priority over pause; any in-progress phase sequence SHALL be cancelled (no further pulses).
REQ-026 crash SHALL be ignored in IDLE and OVER; pause SHALL be ignored outside RUN/PAUSE.
REQ-027 OVER with start=1 SHALL go to IDLE, clearing counter, step count, level to 0; the pulse generation SHALL stay idle until the next IDLE->RUN.
REQ-028 start SHALL be ignored in RUN and PAUSE.

Reset
REQ-029 clear_b=0 SHALL immediately force state IDLE, counter 0, phase sequence cleared, step count 0, level 0, all outputs 0, independent of clock.
REQ-030 Reset asserted mid-sequence SHALL suppress any remaining move_p2/step_done pulse.
REQ-031 After clear_b deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification (BASE_COUNT=15, RAMP_STEPS=2)
REQ-032 start=1, start_level=0 -> RUN; move_p1 16 cycles after counter load, then move_p2, step_done on consecutive cycles; repeat period 16.
REQ-033 Run 2 steps from level 0 -> level=1 after 2nd step_done; next period 8; 4 more steps -> level 2 then 3, periods 4 and 4 (clamp), level stays 3.
REQ-034 pause=1 asserted the cycle move_p1 is high -> move_p2, step_done still issue, then paused=1; counter frozen for 20 cycles; pause=0 -> remaining count resumes exactly.
REQ-035 crash=1 the cycle move_p1 is high -> game_over=1 next cycle, no move_p2/step_done; crash with pause both 1 in RUN -> OVER.
REQ-036 In OVER, start=1 -> IDLE, level=0; start again with start_level=2 -> first period 4 cycles.
REQ-037 clear_b=0 pulsed between clock edges during RUN -> all outputs 0 immediately, state IDLE, no pulses until start.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// ---------------------------------------------------------------------------
// game_tick_scheduler
//
// Paces a two-player game. A programmable down-counter sets the step period.
// Each time it expires, a three-cycle phase sequence is emitted:
// move_p1, then move_p2, then step_done.
// Every RAMP_STEPS completed steps, the speed level rises by one. Each level
// halves the period, and the period never drops below 4 cycles.
//
// Parameters
//   DIV_WIDTH   width of the period counter
//   BASE_COUNT  reload value at level 0 (period = reload + 1 cycles)
//   RAMP_STEPS  completed steps per automatic level increase
//
// Ports
//   clock        in   system clock, rising edge
//   clear_b      in   asynchronous active-low reset
//   start        in   start from IDLE / acknowledge from OVER (level)
//   pause        in   pause request (level)
//   crash        in   collision report, ends the game from RUN or PAUSE
//   start_level  in   [1:0] initial speed level, sampled on IDLE->RUN
//   move_p1      out  one-cycle pulse, advance player 1
//   move_p2      out  one-cycle pulse, advance player 2
//   step_done    out  one-cycle pulse, collision check / redraw slot
//   level        out  [1:0] current speed level (0 slowest, 3 fastest)
//   running      out  high in RUN
//   paused       out  high in PAUSE
//   game_over    out  high in OVER
// ---------------------------------------------------------------------------
module game_tick_scheduler #(
    parameter int unsigned          DIV_WIDTH  = 28,
    parameter logic [DIV_WIDTH-1:0] BASE_COUNT = 28'd49_999_999,
    parameter int unsigned          RAMP_STEPS = 16
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       start,
    input  logic       pause,
    input  logic       crash,
    input  logic [1:0] start_level,
    output logic       move_p1,
    output logic       move_p2,
    output logic       step_done,
    output logic [1:0] level,
    output logic       running,
    output logic       paused,
    output logic       game_over
);

    localparam int unsigned STEP_W = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           lvl_q, lvl_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 p1_q, p1_d;
    logic                 p2_q, p2_d;
    logic                 done_q, done_d;
    logic                 run_q, pse_q, over_q;
    logic                 busy;

    // The period shrinks by halving per level. It is clamped at 3 so that the
    // 3-cycle phase sequence always finishes before the next expiry.
    function automatic logic [DIV_WIDTH-1:0] reload_of(input logic [1:0] lvl);
        logic [DIV_WIDTH-1:0] r;
        r = BASE_COUNT >> lvl;
        if (r < DIV_WIDTH'(3)) begin
            r = DIV_WIDTH'(3);
        end
        return r;
    endfunction

    assign busy = p1_q | p2_q | done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        step_d  = step_q;
        // The phase registers default to cleared. Leaving RUN, or a crash,
        // therefore cancels any sequence that is in flight.
        p1_d    = 1'b0;
        p2_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    lvl_d   = start_level;
                    cnt_d   = reload_of(start_level);
                    step_d  = '0;
                end
            end

            S_RUN: begin
                if (crash) begin
                    state_d = S_OVER;
                end else begin
                    p2_d   = p1_q;
                    done_d = p2_q;

                    // Count the step as the step_done cycle closes. A new
                    // level is picked up only at the next reload.
                    if (done_q) begin
                        if (step_q == STEP_W'(RAMP_STEPS - 1)) begin
                            step_d = '0;
                            if (lvl_q != 2'd3) begin
                                lvl_d = lvl_q + 2'd1;
                            end
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end

                    if (cnt_q == '0) begin
                        cnt_d = reload_of(lvl_q);
                        p1_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DIV_WIDTH'(1);
                    end

                    // The counter still ticks on the edge that enters PAUSE.
                    // An expiry in this same cycle starts a sequence, which
                    // must be allowed to finish first. In either case the
                    // total number of RUN cycles in a period stays exact.
                    if (pause && !busy && (cnt_q != '0)) begin
                        state_d = S_PAUSE;
                    end
                end
            end

            S_PAUSE: begin
                if (crash) begin
                    state_d = S_OVER;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end

            S_OVER: begin
                if (start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                    lvl_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lvl_q   <= '0;
            step_q  <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            pse_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            step_q  <= step_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            done_q  <= done_d;
            run_q   <= (state_d == S_RUN);
            pse_q   <= (state_d == S_PAUSE);
            over_q  <= (state_d == S_OVER);
        end
    end

    assign move_p1   = p1_q;
    assign move_p2   = p2_q;
    assign step_done = done_q;
    assign level     = lvl_q;
    assign running   = run_q;
    assign paused    = pse_q;
    assign game_over = over_q;

endmodule
